// File: rtl/event_generator.sv
// rtl/event_generator.sv - burst generator producing N button pulses of H high / L low cycles.
// Zero high/low times are promoted to one cycle so that every pulse has both a high and a low phase.
module event_generator #(
  parameter int EVT_W = 4,
  parameter int TIM_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [EVT_W-1:0] req_count,
  input  logic [TIM_W-1:0] req_high,
  input  logic [TIM_W-1:0] req_low,
  input  logic             abort,
  output logic             button,
  output logic             busy,
  output logic             done,
  output logic [EVT_W-1:0] sent_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e           state_q;
  logic [EVT_W-1:0] count_q;
  logic [EVT_W-1:0] sent_q;
  logic [TIM_W-1:0] high_q;
  logic [TIM_W-1:0] low_q;
  logic [TIM_W-1:0] timer_q;
  logic             button_q;

  logic [TIM_W-1:0] high_eff;
  logic [TIM_W-1:0] low_eff;

  assign high_eff = (req_high == '0) ? TIM_W'(1) : req_high;
  assign low_eff  = (req_low == '0) ? TIM_W'(1) : req_low;

  // The timer counts down from (phase length - 1), so a full 2^TIM_W-1 phase fits without wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      sent_q   <= '0;
      high_q   <= '0;
      low_q    <= '0;
      timer_q  <= '0;
      button_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            count_q <= req_count;
            high_q  <= high_eff;
            low_q   <= low_eff;
            sent_q  <= '0;
            if (req_count == '0) begin
              state_q <= DONE;
            end else begin
              state_q  <= HIGH;
              button_q <= 1'b1;
              timer_q  <= high_eff - TIM_W'(1);
            end
          end
        end
        HIGH: begin
          if (abort) begin
            state_q  <= IDLE;
            button_q <= 1'b0;
          end else if (timer_q == '0) begin
            state_q  <= LOW;
            button_q <= 1'b0;
            timer_q  <= low_q - TIM_W'(1);
            if (sent_q < count_q) begin
              sent_q <= sent_q + EVT_W'(1);
            end
          end else begin
            timer_q <= timer_q - TIM_W'(1);
          end
        end
        LOW: begin
          if (abort) begin
            state_q  <= IDLE;
            button_q <= 1'b0;
          end else if (timer_q == '0) begin
            if (sent_q < count_q) begin
              state_q  <= HIGH;
              button_q <= 1'b1;
              timer_q  <= high_q - TIM_W'(1);
            end else begin
              state_q <= DONE;
            end
          end else begin
            timer_q <= timer_q - TIM_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q  <= IDLE;
          button_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q == HIGH) || (state_q == LOW);
  assign done       = (state_q == DONE);
  assign button     = button_q;
  assign sent_count = sent_q;

endmodule

// File: tb/tb_event_generator.sv
// tb/tb_event_generator.sv - directed and random bursts checked against a pulse-train reference model.
module tb_event_generator;
  localparam int EVT_W = 4;
  localparam int TIM_W = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             req_valid;
  logic             req_ready;
  logic [EVT_W-1:0] req_count;
  logic [TIM_W-1:0] req_high;
  logic [TIM_W-1:0] req_low;
  logic             abort;
  logic             button;
  logic             busy;
  logic             done;
  logic [EVT_W-1:0] sent_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  event_generator #(.EVT_W(EVT_W), .TIM_W(TIM_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_count  (req_count),
    .req_high   (req_high),
    .req_low    (req_low),
    .abort      (abort),
    .button     (button),
    .busy       (busy),
    .done       (done),
    .sent_count (sent_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int eb, input int ebusy, input int edone,
                           input int eready, input int esent);
    check({tag, " button"}, 32'(button), eb);
    check({tag, " busy"}, 32'(busy), ebusy);
    check({tag, " done"}, 32'(done), edone);
    check({tag, " req_ready"}, 32'(req_ready), eready);
    check({tag, " sent_count"}, 32'(sent_count), esent);
  endtask

  // Pulses whose high phase has finished before cycle k (cycle 1 follows the handshake edge).
  function automatic int sent_at(input int n, input int he, input int le, input int k);
    int p;
    int s;
    p = k - 1;
    s = (p >= he) ? (p - he) / (he + le) + 1 : 0;
    return (s > n) ? n : s;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the first idle cycle afterwards.
  task automatic run_burst(input int n, input int h, input int l, input int a, input bit hold,
                           input int nn, input int nh, input int nl, input bit abort_idle);
    int    he;
    int    le;
    int    per;
    int    t_end;
    int    last;
    int    rises;
    int    eb;
    int    es;
    logic  prev_b;
    string tag;
    he     = (h == 0) ? 1 : h;
    le     = (l == 0) ? 1 : l;
    per    = he + le;
    t_end  = n * per;
    last   = (a > 0) ? a + 1 : t_end + 2;
    rises  = 0;
    prev_b = 1'b0;
    req_valid = 1'b1;
    req_count = n[EVT_W-1:0];
    req_high  = h[TIM_W-1:0];
    req_low   = l[TIM_W-1:0];
    abort     = abort_idle;
    @(posedge clk);
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (k == 1) begin
        abort = 1'b0;
        if (hold) begin
          req_count = nn[EVT_W-1:0];
          req_high  = nh[TIM_W-1:0];
          req_low   = nl[TIM_W-1:0];
        end else begin
          req_valid = 1'b0;
        end
      end
      tag = $sformatf("n%0d h%0d l%0d a%0d k%0d", n, h, l, a, k);
      if (a > 0 && k > a) begin
        check_all(tag, 0, 0, 0, 1, sent_at(n, he, le, a));
      end else if (k <= t_end) begin
        eb = (((k - 1) % per) < he) ? 1 : 0;
        es = sent_at(n, he, le, k);
        check_all(tag, eb, 1, 0, 0, es);
      end else if (k == t_end + 1) begin
        check_all(tag, 0, 0, 1, 0, n);
      end else begin
        check_all(tag, 0, 0, 0, 1, n);
      end
      if (button === 1'b1 && prev_b === 1'b0) rises++;
      prev_b = button;
      if (a > 0 && k == a) abort = 1'b1;
      if (a > 0 && k == a + 1) abort = 1'b0;
      if (a == 0 && abort_idle && k == t_end + 1) abort = 1'b1;
      if (a == 0 && k == t_end + 2) abort = 1'b0;
    end
    if (a == 0) check($sformatf("n%0d h%0d l%0d button rises", n, h, l), rises, n);
  endtask

  initial begin
    int n;
    int h;
    int l;
    int a;
    int he;
    int le;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_count = '0;
    req_high  = '0;
    req_low   = '0;
    abort     = 1'b0;
    #1;
    check_all("reset", 0, 0, 0, 1, 0);
    repeat (2) @(negedge clk);
    check_all("reset held", 0, 0, 0, 1, 0);
    reset_n = 1'b1;

    run_burst(3, 2, 3, 0, 1'b0, 0, 0, 0, 1'b0);
    run_burst(0, 5, 5, 0, 1'b0, 0, 0, 0, 1'b0);
    run_burst(4, 0, 0, 0, 1'b0, 0, 0, 0, 1'b0);
    run_burst(5, 3, 2, 7, 1'b0, 0, 0, 0, 1'b0);
    run_burst(2, 1, 2, 0, 1'b1, 3, 2, 1, 1'b0);
    run_burst(3, 2, 1, 0, 1'b0, 0, 0, 0, 1'b0);
    run_burst(2, 2, 1, 5, 1'b0, 0, 0, 0, 1'b0);
    run_burst(2, 1, 1, 0, 1'b0, 0, 0, 0, 1'b1);
    run_burst(0, 1, 1, 0, 1'b0, 0, 0, 0, 1'b1);
    run_burst(1, 255, 255, 0, 1'b0, 0, 0, 0, 1'b0);
    run_burst(15, 0, 0, 0, 1'b0, 0, 0, 0, 1'b0);
    run_burst(15, 1, 2, 0, 1'b0, 0, 0, 0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      n  = $urandom_range(0, 15);
      h  = $urandom_range(0, 6);
      l  = $urandom_range(0, 6);
      he = (h == 0) ? 1 : h;
      le = (l == 0) ? 1 : l;
      a  = 0;
      if (n > 0 && $urandom_range(0, 2) == 0) a = $urandom_range(1, n * (he + le));
      run_burst(n, h, l, a, 1'b0, 0, 0, 0, 1'(($urandom_range(0, 3) == 0)));
    end

    req_valid = 1'b1;
    req_count = 4'd15;
    req_high  = 8'd2;
    req_low   = 8'd2;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("mid-burst busy", 32'(busy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_all("async reset", 0, 0, 0, 1, 0);
    @(negedge clk);
    check_all("reset after edge", 0, 0, 0, 1, 0);
    reset_n = 1'b1;
    run_burst(2, 1, 1, 0, 1'b0, 0, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
